// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and alignment check for the memory-stage controller
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MERGE = 1'b1;

    // Size 2'b11 is handled like a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
            default: r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load lane extract/extend and store lane merge (combinational)
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_ld_word,
    input  logic [1:0]  i_ld_off,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    output logic [31:0] o_ld_data,
    input  logic [31:0] i_st_word,
    input  logic [1:0]  i_st_off,
    input  logic [1:0]  i_st_size,
    input  logic [15:0] i_st_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        w_byte = 8'h00;
        case (i_ld_off)
            2'd0: w_byte = i_ld_word[7:0];
            2'd1: w_byte = i_ld_word[15:8];
            2'd2: w_byte = i_ld_word[23:16];
            2'd3: w_byte = i_ld_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        w_sext = ~i_ld_unsigned;

        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{w_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{w_sext & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

    always_comb begin
        o_st_word = i_st_word;
        case (i_st_size)
            SZ_BYTE: begin
                case (i_st_off)
                    2'd0: o_st_word[7:0]   = i_st_data[7:0];
                    2'd1: o_st_word[15:8]  = i_st_data[7:0];
                    2'd2: o_st_word[23:16] = i_st_data[7:0];
                    2'd3: o_st_word[31:24] = i_st_data[7:0];
                    default: o_st_word = i_st_word;
                endcase
            end
            SZ_HALF: begin
                if (i_st_off[1]) o_st_word[31:16] = i_st_data;
                else             o_st_word[15:0]  = i_st_data;
            end
            default: o_st_word = i_st_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage controller: loads, stores and sub-word read-modify-write
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 stall,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rdata_valid,
    output logic                 misalign_err,
    output logic                 ram_ena,
    output logic                 ram_wena,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [WIDTH-1:0]     ram_wdata,
    input  logic [WIDTH-1:0]     ram_rdata
);

    logic [0:0]           r_state;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_rdata_valid;
    logic                 r_misalign_err;
    logic [WIDTH-1:0]     r_cap_word;
    logic [ADDR_BITS-1:0] r_cap_addr;
    logic [1:0]           r_cap_off;
    logic [1:0]           r_cap_size;
    logic [15:0]          r_cap_wdata;

    logic [ADDR_BITS-1:0] w_req_addr;
    logic                 w_misalign;
    logic                 w_go;
    logic                 w_ld;
    logic                 w_st_word;
    logic                 w_st_sub;
    logic [WIDTH-1:0]     w_ld_data;
    logic [WIDTH-1:0]     w_merged;
    logic                 w_unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the RAM size.
    assign w_req_addr    = req_addr[ADDR_BITS+1:2];
    assign w_unused_addr = ^req_addr[31:ADDR_BITS+2];
    assign w_misalign    = req_valid && misaligned(req_size, req_addr[1:0]);
    assign w_go          = req_valid && !w_misalign;
    assign w_ld          = w_go && !req_we;
    assign w_st_word     = w_go && req_we && req_size[1];
    assign w_st_sub      = w_go && req_we && !req_size[1];

    mem_lane_align u_align (
        .i_ld_word     (ram_rdata),
        .i_ld_off      (req_addr[1:0]),
        .i_ld_size     (req_size),
        .i_ld_unsigned (req_unsigned),
        .o_ld_data     (w_ld_data),
        .i_st_word     (r_cap_word),
        .i_st_off      (r_cap_off),
        .i_st_size     (r_cap_size),
        .i_st_data     (r_cap_wdata),
        .o_st_word     (w_merged)
    );

    always_comb begin
        if (r_state == ST_MERGE) begin
            ram_ena   = 1'b1;
            ram_wena  = 1'b1;
            ram_addr  = r_cap_addr;
            ram_wdata = w_merged;
            stall     = 1'b0;
        end else begin
            ram_ena   = w_go;
            ram_wena  = w_st_word;
            ram_addr  = w_req_addr;
            ram_wdata = req_wdata;
            stall     = w_st_sub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rdata        <= '0;
            r_rdata_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_cap_word     <= '0;
            r_cap_addr     <= '0;
            r_cap_off      <= 2'b00;
            r_cap_size     <= 2'b00;
            r_cap_wdata    <= 16'h0000;
        end else if (r_state == ST_MERGE) begin
            // The held request is retiring; the live req_* inputs are ignored.
            r_state        <= ST_IDLE;
            r_rdata_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_rdata_valid  <= w_ld;
            r_misalign_err <= w_misalign;
            if (w_ld) begin
                r_rdata <= w_ld_data;
            end
            if (w_st_sub) begin
                r_state     <= ST_MERGE;
                r_cap_word  <= ram_rdata;
                r_cap_addr  <= w_req_addr;
                r_cap_off   <= req_addr[1:0];
                r_cap_size  <= req_size;
                r_cap_wdata <= req_wdata[15:0];
            end
        end
    end

    assign rdata        = r_rdata;
    assign rdata_valid  = r_rdata_valid;
    assign misalign_err = r_misalign_err;

endmodule
